uart_transmitter: RTL and testbench

//  8N1 UART transmitter, LSB first. Sends bytes from fabric logic to the host over TxD.
//  A small FIFO lets a producer queue several bytes back-to-back.

---
 rtl/uart_transmitter.sv | 190 +++++++++++++++++++
 tb/tb_uart_transmitter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: UART transmitter, LSB first, fed by a small byte FIFO.
// Queued bytes go out back-to-back as 8N1 frames. Defining UART_TX_PARITY_EN
// inserts an even-parity bit after the data bits, which gives an 11-bit frame.
// Ports:
//   clk        : system clock, all logic on posedge
//   reset      : asynchronous active-high reset
//   TxData     : byte to queue, taken when tx_valid && tx_ready
//   tx_valid   : producer offers TxData
//   tx_ready   : FIFO not full (registered)
//   TxD        : serial line, idles high (registered)
//   busy       : frame in progress or FIFO non-empty (registered)
//   fifo_count : bytes queued, excluding the frame on the wire (registered)
module uart_transmitter #(
  parameter int unsigned clk_freq   = 100_000_000,
  parameter int unsigned baud_rate  = 9_600,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned div_bit    = clk_freq / baud_rate
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  TxData,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        TxD,
  output logic                        busy,
  output logic [$clog2(fifo_depth):0] fifo_count
);

  localparam int unsigned PTR_W  = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned CNT_W  = $clog2(fifo_depth) + 1;
  localparam int unsigned BAUD_W = (div_bit > 1) ? $clog2(div_bit) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t              state, state_next;
  logic [7:0]          mem [fifo_depth];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count_next;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_cnt;
  logic [7:0]          shift;
  logic                push_c, pop_c, bit_end_c, txd_c;
`ifdef UART_TX_PARITY_EN
  logic                parity_bit;
`endif

  assign push_c    = tx_valid && tx_ready;
  assign bit_end_c = (baud_cnt == BAUD_W'(div_bit - 1));

  // Queue occupancy after this edge; push and pop together cancel out.
  always_comb begin
    count_next = fifo_count;
    if (push_c && !pop_c)
      count_next = fifo_count + 1'b1;
    else if (!push_c && pop_c)
      count_next = fifo_count - 1'b1;
  end

  // FIFO storage; not reset, only pointers and count carry state.
  always_ff @(posedge clk) begin
    if (push_c)
      mem[wr_ptr] <= TxData;
  end

  // FIFO pointers, occupancy and ready flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tx_ready   <= 1'b1;
    end else begin
      if (push_c)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_c)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_next;
      tx_ready   <= (count_next != CNT_W'(fifo_depth));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // FSM next state; a pop happens on leaving IDLE or at the end of STOP.
  always_comb begin
    state_next = state;
    pop_c      = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop_c      = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_end_c)
          state_next = DATA;
      end
      DATA: begin
        if (bit_end_c && (bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_c)
          state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end_c) begin
          if (fifo_count != '0) begin
            pop_c      = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM output: line level for the current state, registered below.
  always_comb begin
    txd_c = 1'b1;
    case (state)
      START:  txd_c = 1'b0;
      DATA:   txd_c = shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: txd_c = parity_bit;
`endif
      default: txd_c = 1'b1;
    endcase
  end

  // Baud/bit counters and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (pop_c) begin
      shift      <= mem[rd_ptr];
      baud_cnt   <= '0;
      bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= ^mem[rd_ptr];
`endif
    end else if (state != IDLE) begin
      baud_cnt <= bit_end_c ? '0 : baud_cnt + 1'b1;
      if (state == START)
        bit_cnt <= '0;
      // Shift lands on the edge ending a data bit, so TxD changes on the next.
      if ((state == DATA) && bit_end_c) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      TxD  <= 1'b1;
      busy <= 1'b0;
    end else begin
      TxD  <= txd_c;
      busy <= (state_next != IDLE) || (count_next != '0);
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int          DIV      = 10;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
`else
  localparam int          FRAME_BITS = 10;
`endif
  localparam int          FRAME_CLK = FRAME_BITS * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] TxData;
  logic       tx_valid;
  logic       tx_ready;
  logic       TxD;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int passed = 0;
  logic [7:0] stim [256];

  uart_transmitter #(
    .clk_freq   (CLK_FREQ),
    .baud_rate  (BAUD),
    .fifo_depth (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .TxData     (TxData),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .TxD        (TxD),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Expected line level for frame bit idx of byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    logic [7:0] v;
    v = b;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return v[3'(idx - 1)];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^v;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    tx_valid = 1'b0;
    TxData   = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({TxD, tx_ready, busy, fifo_count} !== 6'b110000)
      $display("FAIL reset_values: got %b want 110000", {TxD, tx_ready, busy, fifo_count});
    else passed++;
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({TxD, tx_ready, busy, fifo_count} !== 6'b110000)
        $display("FAIL idle_cycle_%0d: got %b want 110000", i, {TxD, tx_ready, busy, fifo_count});
      else passed++;
    end
  endtask

  // One byte into an idle block, checked clock by clock.
  task automatic test_single(input logic [7:0] v);
    @(negedge clk);
    tx_valid = 1'b1;
    TxData   = v;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if ({fifo_count, busy, TxD, tx_ready} !== 6'b001111)
      $display("FAIL single_%h_push: got %b want 001111", v, {fifo_count, busy, TxD, tx_ready});
    else passed++;
    @(negedge clk);
    checks++;
    if ({fifo_count, busy, TxD} !== 5'b00011)
      $display("FAIL single_%h_pop: got %b want 00011", v, {fifo_count, busy, TxD});
    else passed++;
    for (int k = 0; k < FRAME_CLK; k++) begin
      logic eb, ebusy;
      @(negedge clk);
      eb    = exp_bit(v, k / DIV);
      ebusy = (k < FRAME_CLK - 1);
      checks++;
      if ({TxD, busy} !== {eb, ebusy})
        $display("FAIL single_%h_clk%0d: TxD,busy got %b want %b", v, k, {TxD, busy}, {eb, ebusy});
      else passed++;
    end
    @(negedge clk);
    checks++;
    if ({TxD, busy, fifo_count} !== 5'b10000)
      $display("FAIL single_%h_end: got %b want 10000", v, {TxD, busy, fifo_count});
    else passed++;
  endtask

  // Pushes stim[0..n-1] whenever ready and decodes the line at mid-bit.
  task automatic test_stream(input int n, input bit chk_full, input string tag);
    int cyc = 0, sent = 0, got = 0, fc = 0, start_prev = -1;
    bit inframe = 0, last_push = 0;
    logic [7:0] sh = 8'h00;
    while (got < n && cyc < n * FRAME_CLK + 50) begin
      @(negedge clk);
      cyc++;
      if (chk_full && last_push && sent == 5) begin
        checks++;
        if ({tx_ready, fifo_count} !== 4'b0100)
          $display("FAIL %s_full: tx_ready,count got %b want 0100", tag, {tx_ready, fifo_count});
        else passed++;
      end
      if (inframe) fc++;
      else if (TxD === 1'b0) begin
        inframe = 1;
        fc = 0;
        if (start_prev >= 0) begin
          checks++;
          if (cyc - start_prev !== FRAME_CLK)
            $display("FAIL %s_gap%0d: start spacing %0d want %0d", tag, got, cyc - start_prev, FRAME_CLK);
          else passed++;
        end
        start_prev = cyc;
      end
      if (inframe && (fc % DIV) == 5) begin
        int b;
        b = fc / DIV;
        if (b >= 1 && b <= 8) sh[3'(b - 1)] = TxD;
`ifdef UART_TX_PARITY_EN
        if (b == 9) begin
          checks++;
          if (TxD !== ^stim[got])
            $display("FAIL %s_parity%0d: got %b want %b", tag, got, TxD, ^stim[got]);
          else passed++;
        end
`endif
        if (b == FRAME_BITS - 1) begin
          checks++;
          if ({TxD, sh} !== {1'b1, stim[got]})
            $display("FAIL %s_byte%0d: stop,data got %b_%h want 1_%h", tag, got, TxD, sh, stim[got]);
          else passed++;
          got++;
          inframe = 0;
        end
      end
      last_push = (sent < n) && tx_ready;
      tx_valid  = last_push;
      if (sent < n) TxData = stim[sent];
      if (last_push) sent++;
    end
    tx_valid = 1'b0;
    if (got < n) begin
      checks++;
      $display("FAIL %s_timeout: frames got %0d want %0d", tag, got, n);
    end
    repeat (DIV) @(negedge clk);
    checks++;
    if ({TxD, busy, tx_ready, fifo_count} !== 6'b101000)
      $display("FAIL %s_drain: got %b want 101000", tag, {TxD, busy, tx_ready, fifo_count});
    else passed++;
  endtask

  task automatic test_back_to_back();
    stim[0] = 8'hA3; stim[1] = 8'h0F; stim[2] = 8'hFF; stim[3] = 8'h00; stim[4] = 8'h81;
    test_stream(5, 1'b1, "b2b");
  endtask

  task automatic test_loopback();
    for (int i = 0; i < 256; i++) stim[i] = 8'($urandom_range(0, 255));
    test_stream(256, 1'b0, "loop");
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    tx_valid = 1'b1; TxData = 8'hA5;
    @(negedge clk);
    TxData = 8'h11;
    @(negedge clk);
    TxData = 8'h22;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (44) @(negedge clk);
    // Now mid data bit 3 of 0xA5 (a 0), with two bytes still queued.
    checks++;
    if ({TxD, busy, fifo_count} !== 5'b01010)
      $display("FAIL midframe_pre: got %b want 01010", {TxD, busy, fifo_count});
    else passed++;
    reset = 1'b1;
    #1;
    checks++;
    if ({TxD, tx_ready, busy, fifo_count} !== 6'b110000)
      $display("FAIL midframe_reset: got %b want 110000", {TxD, tx_ready, busy, fifo_count});
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      @(negedge clk);
      checks++;
      if ({TxD, busy, fifo_count} !== 5'b10000)
        $display("FAIL midframe_quiet%0d: got %b want 10000", i, {TxD, busy, fifo_count});
      else passed++;
    end
    stim[0] = 8'h3C;
    test_stream(1, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single(8'h55);
    test_back_to_back();
    test_loopback();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_single(8'h07);
    test_single(8'h03);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d want %0d", passed, checks);
    $fatal(1);
  end

endmodule
